// File: rtl/instr_refill_ctrl.sv
// Instruction cache line refill: fetches one line as single-outstanding word
// reads, assembles it and strobes a line write unless a flush dropped it.
module instr_refill_ctrl #(
    parameter int BLOCK_WIDTH = 512,
    parameter int WORD_SIZE   = 32,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   i_miss_req,
    input  logic [ADDR_WIDTH-1:0]  i_miss_addr,
    input  logic                   i_flush,
    output logic                   o_busy,
    output logic                   o_write_en,
    output logic [ADDR_WIDTH-1:0]  o_refill_addr,
    output logic [BLOCK_WIDTH-1:0] o_block,
    output logic                   o_refill_done,
    output logic                   o_access_fault,
    output logic                   o_mem_req_valid,
    input  logic                   i_mem_req_ready,
    output logic [ADDR_WIDTH-1:0]  o_mem_addr,
    input  logic                   i_mem_rvalid,
    input  logic [WORD_SIZE-1:0]   i_mem_rdata,
    input  logic                   i_mem_rerr
);

    // state | meaning
    // IDLE  | waiting for a miss
    // REQ   | read request for beat k presented
    // WAIT  | request accepted, waiting for read data
    // WRITE | line complete, write strobe (unless dropped) and done pulse
    // FAULT | error response seen, fault pulse, line discarded
    typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, FAULT} state_t;

    localparam int BEATS = BLOCK_WIDTH / WORD_SIZE;
    localparam logic [3:0] LAST_BEAT = 4'(BEATS - 1);

    state_t                 state;
    logic [3:0]             k;
    logic                   drop;
    logic                   in_write;
    logic [BLOCK_WIDTH-1:0] line_buf;
    logic [BLOCK_WIDTH-1:0] line_next;

    always_comb begin
        line_next = line_buf;
        line_next[int'(k)*WORD_SIZE +: WORD_SIZE] = i_mem_rdata;
    end

    assign o_mem_addr = {o_refill_addr[ADDR_WIDTH-1:6], 6'b0} + ADDR_WIDTH'({k, 2'b00});

    // A flush arriving in the write cycle itself must still suppress the strobe.
    assign o_write_en = in_write & ~drop & ~i_flush;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state           <= IDLE;
            k               <= '0;
            drop            <= 1'b0;
            in_write        <= 1'b0;
            line_buf        <= '0;
            o_block         <= '0;
            o_refill_addr   <= '0;
            o_busy          <= 1'b0;
            o_refill_done   <= 1'b0;
            o_access_fault  <= 1'b0;
            o_mem_req_valid <= 1'b0;
        end else begin
            o_refill_done  <= 1'b0;
            o_access_fault <= 1'b0;
            in_write       <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_miss_req) begin
                        o_refill_addr   <= i_miss_addr;
                        k               <= '0;
                        drop            <= 1'b0;
                        o_busy          <= 1'b1;
                        o_mem_req_valid <= 1'b1;
                        state           <= REQ;
                    end
                end
                REQ: begin
                    if (i_flush) drop <= 1'b1;
                    if (i_mem_req_ready) begin
                        o_mem_req_valid <= 1'b0;
                        state           <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_flush) drop <= 1'b1;
                    if (i_mem_rvalid) begin
                        if (i_mem_rerr) begin
                            o_access_fault <= 1'b1;
                            state          <= FAULT;
                        end else begin
                            line_buf <= line_next;
                            if (k == LAST_BEAT) begin
                                o_block       <= line_next;
                                in_write      <= 1'b1;
                                o_refill_done <= 1'b1;
                                state         <= WRITE;
                            end else begin
                                k               <= k + 4'd1;
                                o_mem_req_valid <= 1'b1;
                                state           <= REQ;
                            end
                        end
                    end
                end
                WRITE: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                FAULT: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    o_busy          <= 1'b0;
                    o_mem_req_valid <= 1'b0;
                    state           <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_refill_ctrl.sv
// Randomized bench for instr_refill_ctrl: a memory responder plus a
// transaction-level line model checks addresses, assembled line and pulses.
module tb_instr_refill_ctrl;

    logic         clk = 1'b0;
    logic         arst;
    logic         miss_req;
    logic [31:0]  miss_addr;
    logic         flush;
    logic         busy;
    logic         write_en;
    logic [31:0]  refill_addr;
    logic [511:0] block;
    logic         refill_done;
    logic         access_fault;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [31:0]  mem_addr;
    logic         mem_rvalid;
    logic [31:0]  mem_rdata;
    logic         mem_rerr;

    instr_refill_ctrl dut (
        .clk             (clk),
        .arst            (arst),
        .i_miss_req      (miss_req),
        .i_miss_addr     (miss_addr),
        .i_flush         (flush),
        .o_busy          (busy),
        .o_write_en      (write_en),
        .o_refill_addr   (refill_addr),
        .o_block         (block),
        .o_refill_done   (refill_done),
        .o_access_fault  (access_fault),
        .o_mem_req_valid (mem_req_valid),
        .i_mem_req_ready (mem_req_ready),
        .o_mem_addr      (mem_addr),
        .i_mem_rvalid    (mem_rvalid),
        .i_mem_rdata     (mem_rdata),
        .i_mem_rerr      (mem_rerr)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [511:0] blk_model = '0;
    bit           blk_known = 1'b1;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_we"},    write_en, 0);
        check({tag, "_done"},  refill_done, 0);
        check({tag, "_fault"}, access_fault, 0);
        check({tag, "_valid"}, mem_req_valid, 0);
        check({tag, "_block"}, block, 0);
        check({tag, "_raddr"}, refill_addr, 0);
        check({tag, "_maddr"}, mem_addr, 0);
    endtask

    // One refill from the IDLE cycle to the IDLE cycle after it ends.
    // rnd=0: exact stall/latency values, rnd=1: random up to those values.
    task automatic run_refill(input logic [31:0] addr, input logic [31:0] dbase,
                              input int rdy_d, input int rv_d, input bit rnd,
                              input int err_beat, input int flush_beat, input bit flush_wr,
                              input bit hold_miss, input logic [31:0] next_addr,
                              input bit zero_chk, input int rst_beat);
        logic [31:0]  base;
        logic [31:0]  exp_addr;
        logic [511:0] exp_blk;
        int reqs = 0, beats = 0, cyc = 0, stall = 0, rvw = 0;
        int we = 0, dn = 0, ft = 0;
        bit outst = 0, stall_init = 0, flush_nxt = 0, fin = 0, dropped = 0, rst_hit = 0;

        base = {addr[31:6], 6'b0};
        for (int i = 0; i < 16; i++) exp_blk[i*32 +: 32] = dbase + 32'(i);

        miss_req  = 1'b1;
        miss_addr = addr;
        step();
        cyc = 1;
        if (hold_miss) miss_addr = next_addr;
        else miss_req = 1'b0;

        while (!fin && cyc < 3000) begin
            flush         = flush_nxt;
            flush_nxt     = 0;
            mem_rvalid    = 1'b0;
            mem_rerr      = 1'b0;
            mem_req_ready = 1'b0;
            mem_rdata     = $urandom;
            #1;
            if (rst_beat >= 0 && outst && reqs == rst_beat + 1) begin
                arst = 1'b1;
                #1;
                check_all_zero("rst_mid");
                miss_req = 1'b0;
                flush    = 1'b0;
                step();
                arst      = 1'b0;
                blk_model = '0;
                blk_known = 1'b1;
                rst_hit   = 1;
                break;
            end
            if (blk_known && !refill_done) check("block_hold", block, blk_model);
            if (write_en) begin
                we++;
                check("refill_addr", refill_addr, addr);
                check("block", block, exp_blk);
                if (zero_chk) check("we_cycle", cyc, 33);
            end
            if (refill_done) begin
                dn++;
                fin = 1;
                if (zero_chk) check("done_cycle", cyc, 33);
                if (we > 0) begin
                    blk_model = exp_blk;
                    blk_known = 1'b1;
                end else blk_known = 1'b0;
            end
            if (access_fault) begin
                ft++;
                fin = 1;
            end
            if (mem_req_valid) begin
                exp_addr = base + 32'(4 * reqs);
                check("one_outstanding", outst, 0);
                check("mem_addr", mem_addr, exp_addr);
                check("busy_req", busy, 1);
                if (!stall_init) begin
                    stall      = rnd ? int'($urandom_range(rdy_d, 0)) : rdy_d;
                    stall_init = 1;
                end
                if (stall == 0) begin
                    mem_req_ready = 1'b1;
                    reqs++;
                    outst      = 1;
                    stall_init = 0;
                    rvw        = rnd ? int'($urandom_range(rv_d, 0)) : rv_d;
                end else stall--;
                if ($urandom_range(3, 0) == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rerr   = 1'($urandom_range(1, 0));
                end
            end else if (outst) begin
                if (reqs == flush_beat + 1) begin
                    flush   = 1'b1;
                    dropped = 1;
                end
                if (rvw == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rerr   = (beats == err_beat);
                    mem_rdata  = dbase + 32'(beats);
                    beats++;
                    outst = 0;
                    if (beats == 16 && flush_wr) begin
                        flush_nxt = 1;
                        dropped   = 1;
                    end
                end else rvw--;
            end
            step();
            cyc++;
        end

        flush         = 1'b0;
        mem_rvalid    = 1'b0;
        mem_req_ready = 1'b0;
        if (!rst_hit) begin
            check("completed", fin, 1);
            #1;
            check("busy_after", busy, 0);
            if (err_beat >= 0) begin
                check("fault_cnt", ft, 1);
                check("fault_we", we, 0);
                check("fault_done", dn, 0);
                check("fault_reqs", reqs, err_beat + 1);
                for (int i = 0; i < 3; i++) begin
                    step();
                    check("no_req_after_fault", mem_req_valid, 0);
                end
            end else begin
                check("reqs", reqs, 16);
                check("done_cnt", dn, 1);
                check("fault_none", ft, 0);
                check("we_cnt", we, dropped ? 0 : 1);
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        arst          = 1'b1;
        miss_req      = 1'b0;
        miss_addr     = '0;
        flush         = 1'b0;
        mem_req_ready = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = '0;
        mem_rerr      = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        arst = 1'b0;
        step();

        // flush while idle must not affect the next refill
        flush = 1'b1;
        step();
        flush = 1'b0;
        run_refill(32'h0000_1234, 32'h0000_1000, 0, 0, 0, -1, -1, 0, 0, '0, 1, -1);

        run_refill($urandom, $urandom, 3, 2, 0, -1, -1, 0, 0, '0, 0, -1);
        run_refill($urandom, $urandom, 1, 1, 1, 7, -1, 0, 0, '0, 0, -1);
        run_refill($urandom, $urandom, 1, 1, 1, -1, 4, 0, 0, '0, 0, -1);
        run_refill($urandom, $urandom, 1, 1, 1, -1, -1, 1, 0, '0, 0, -1);

        a = $urandom;
        b = $urandom;
        run_refill(a, $urandom, 2, 2, 1, -1, -1, 0, 1, b, 0, -1);
        run_refill(b, $urandom, 0, 0, 0, -1, -1, 0, 0, '0, 1, -1);

        run_refill($urandom, $urandom, 0, 0, 0, -1, -1, 0, 0, '0, 0, 9);
        run_refill(32'hFFFF_FFC0, $urandom, 0, 0, 0, -1, -1, 0, 0, '0, 1, -1);

        for (int t = 0; t < 12; t++) begin
            int eb;
            int fb;
            eb = ($urandom_range(3, 0) == 0) ? int'($urandom_range(15, 0)) : -1;
            fb = ($urandom_range(3, 0) == 0) ? int'($urandom_range(15, 0)) : -1;
            run_refill($urandom, $urandom, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                       1, eb, fb, 1'($urandom_range(5, 0) == 0), 0, '0, 0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
